// File: rtl/keypad_hex_entry_if.sv
// ---------------------------------------------------------------------------
// keypad_hex_entry_if
// Single-nibble key event channel between the keypad scanner (master) and
// its consumer (slave).
//   o_key        master->slave  hex code of the pending press event
//   o_key_valid  master->slave  event pending; held until accepted
//   i_key_ready  slave->master  consumer accepts the pending event
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface keypad_hex_entry_if;
  logic [3:0] o_key;
  logic       o_key_valid;
  logic       i_key_ready;

  modport master (
    output o_key,
    output o_key_valid,
    input  i_key_ready
  );

  modport slave (
    input  o_key,
    input  o_key_valid,
    output i_key_ready
  );
endinterface

// File: rtl/keypad_hex_entry.sv
// ---------------------------------------------------------------------------
// keypad_hex_entry
// 4x4 matrix keypad scanner with debounce, hex decode and a 32-bit entry
// shift register. Each accepted press is shifted into o_data and offered
// as a one-nibble event on the key_if valid/ready channel.
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN
//   defined   -> a held key re-emits its code every REPEAT_CNT held samples
//   undefined -> exactly one event per press
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   i_col[3:0] keypad columns, pulled up, low = closed
//   o_row[3:0] row drive, exactly one bit low
//   i_clr      synchronous clear of o_data and o_overrun
//   o_data     entry word, newest nibble in [3:0]
//   o_overrun  sticky: an event was dropped because the channel was full
//   key_if     event channel (master side)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module keypad_hex_entry #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 10,
  parameter int REPEAT_CNT   = 500
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 i_col,
  output logic [3:0]                 o_row,
  input  logic                       i_clr,
  output logic [31:0]                o_data,
  output logic                       o_overrun,
  keypad_hex_entry_if.master         key_if
);

  localparam int DIV_W   = $clog2(SCAN_DIV);
  localparam int CNT_MAX = (REPEAT_CNT > DEBOUNCE_CNT) ? REPEAT_CNT : DEBOUNCE_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

  state_t             state;
  logic [3:0]         col_s1;
  logic [3:0]         scol;
  logic [DIV_W-1:0]   div;
  logic [1:0]         row_idx;
  logic [1:0]         col_idx;
  logic [3:0]         col_pat;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               sample;
  logic               one_low;
  logic               emit;
  logic [3:0]         code;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] low_col(input logic [3:0] c);
    logic [1:0] idx;
    case (c)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Two-flop column synchronizer; idles at "all open".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1 <= 4'hF;
      scol   <= 4'hF;
    end else begin
      col_s1 <= i_col;
      scol   <= col_s1;
    end
  end

  assign sample  = (div == DIV_W'(SCAN_DIV - 1));
  assign cnt_inc = cnt + CNT_W'(1);
  assign one_low = (scol == 4'b1110) || (scol == 4'b1101) ||
                   (scol == 4'b1011) || (scol == 4'b0111);
  assign code    = key_code(row_idx, col_idx);

  // Emit is decided on the sample that completes debounce (or a repeat
  // interval) so that the event registers on that same edge.
  always_comb begin
    emit = 1'b0;
    if (sample) begin
      if (state == DEB_PRESS && scol == col_pat && cnt_inc == CNT_W'(DEBOUNCE_CNT))
        emit = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
      if (state == HELD && scol != 4'hF && cnt_inc == CNT_W'(REPEAT_CNT))
        emit = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SCAN;
      div     <= '0;
      cnt     <= '0;
      row_idx <= 2'd0;
      o_row   <= 4'b1110;
      col_idx <= 2'd0;
      col_pat <= 4'hF;
    end else begin
      div <= sample ? '0 : div + DIV_W'(1);
      if (sample) begin
        case (state)
          SCAN: begin
            if (one_low) begin
              col_pat <= scol;
              col_idx <= low_col(scol);
              cnt     <= CNT_W'(1);
              state   <= DEB_PRESS;
            end else begin
              // Open or ghosted (two or more low): move on to the next row.
              row_idx <= row_idx + 2'd1;
              o_row   <= ~(4'b0001 << (row_idx + 2'd1));
            end
          end
          DEB_PRESS: begin
            if (scol == col_pat) begin
              if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
                cnt   <= '0;
                state <= HELD;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt     <= '0;
              row_idx <= row_idx + 2'd1;
              o_row   <= ~(4'b0001 << (row_idx + 2'd1));
              state   <= SCAN;
            end
          end
          HELD: begin
            if (scol == 4'hF) begin
              cnt   <= CNT_W'(1);
              state <= DEB_REL;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            else if (cnt_inc == CNT_W'(REPEAT_CNT)) begin
              cnt <= '0;
            end else begin
              cnt <= cnt_inc;
            end
`endif
          end
          default: begin
            if (scol == 4'hF) begin
              if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
                cnt     <= '0;
                row_idx <= row_idx + 2'd1;
                o_row   <= ~(4'b0001 << (row_idx + 2'd1));
                state   <= SCAN;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              // Release bounce: back to held, no new event.
              cnt   <= '0;
              state <= HELD;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_if.o_key       <= 4'h0;
      key_if.o_key_valid <= 1'b0;
      o_data             <= 32'h0;
      o_overrun          <= 1'b0;
    end else begin
      if (emit)
        o_data <= i_clr ? {28'h0, code} : {o_data[27:0], code};
      else if (i_clr)
        o_data <= 32'h0;

      if (emit && (!key_if.o_key_valid || key_if.i_key_ready)) begin
        key_if.o_key       <= code;
        key_if.o_key_valid <= 1'b1;
      end else if (key_if.i_key_ready) begin
        key_if.o_key_valid <= 1'b0;
      end

      // A drop in the clear cycle still sets the flag.
      if (emit && key_if.o_key_valid && !key_if.i_key_ready)
        o_overrun <= 1'b1;
      else if (i_clr)
        o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
`timescale 1ns/1ps
module tb_keypad_hex_entry;
  localparam int SD = 4;
  localparam int DC = 3;
  localparam int RC = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        clr = 1'b0;
  logic [31:0] data;
  logic        ovr;
  logic [15:0] pressed = 16'h0;

  int n_checks = 0;
  int n_pass   = 0;
  int ev_count = 0;
  logic [3:0] got[$];

  // Key legend in row-major order, straight from the keypad layout.
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  keypad_hex_entry_if kif ();

  keypad_hex_entry #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC), .REPEAT_CNT(RC)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_col    (col),
    .o_row    (row),
    .i_clr    (clr),
    .o_data   (data),
    .o_overrun(ovr),
    .key_if   (kif.master)
  );

  always #5 clk = ~clk;

  // Physical matrix: a closed switch pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  // Accepted transfers, observed mid-cycle.
  always @(negedge clk) begin
    if (rst && kif.o_key_valid && kif.i_key_ready) begin
      got.push_back(kif.o_key);
      ev_count++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_row(input logic [3:0] want, output bit ok);
    int n = 0;
    while (row == want && n < 64) begin tick(1); n++; end
    while (row != want && n < 64) begin tick(1); n++; end
    ok = (row == want) && (n < 64);
  endtask

  function automatic logic [3:0] row_of(input int idx);
    return ~(4'b0001 << (idx / 4));
  endfunction

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  // Press while the key's row is driven so the emit lands 12 cycles later,
  // then release before any repeat interval could elapse.
  task automatic press_key(input int idx);
    bit ok;
    wait_row(row_of(idx), ok);
    if (!ok) begin
      n_checks++;
      $display("FAIL row_wait: row=%b never reached %b", row, row_of(idx));
    end
    pressed[idx] = 1'b1;
    tick(14);
    pressed = 16'h0;
    tick(40);
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst = 1'b0;
    kif.i_key_ready = 1'b1;
    tick(3);
    rst = 1'b1;
    n_checks++; if (row !== 4'b1110) $display("FAIL reset_row: got %b want 1110", row); else n_pass++;
    n_checks++; if (kif.o_key !== 4'h0) $display("FAIL reset_key: got %h want 0", kif.o_key); else n_pass++;
    n_checks++; if (kif.o_key_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", kif.o_key_valid); else n_pass++;
    n_checks++; if (data !== 32'h0) $display("FAIL reset_data: got %h want 0", data); else n_pass++;
    n_checks++; if (ovr !== 1'b0) $display("FAIL reset_ovr: got %b want 0", ovr); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick(SD);
      n_checks++;
      if (row !== exp_rows[k]) $display("FAIL row_cycle%0d: got %b want %b", k, row, exp_rows[k]);
      else n_pass++;
    end
  endtask

  task automatic test_clean_presses();
    bit ok;
    int base = ev_count;
    wait_row(4'b1101, ok);
    n_checks++; if (!ok) $display("FAIL clean_wait: row=%b want 1101", row); else n_pass++;
    pressed[6] = 1'b1;
    tick(11);
    n_checks++; if (kif.o_key_valid !== 1'b0) $display("FAIL latency_early: valid=%b want 0", kif.o_key_valid); else n_pass++;
    tick(1);
    n_checks++; if (kif.o_key_valid !== 1'b1) $display("FAIL latency_on: valid=%b want 1", kif.o_key_valid); else n_pass++;
    n_checks++; if (kif.o_key !== 4'h6) $display("FAIL clean_key6: got %h want 6", kif.o_key); else n_pass++;
    n_checks++; if (data !== 32'h6) $display("FAIL clean_data6: got %h want 00000006", data); else n_pass++;
    tick(1);
    n_checks++; if (kif.o_key_valid !== 1'b0) $display("FAIL clean_pulse: valid=%b want 0", kif.o_key_valid); else n_pass++;
    tick(1);
    pressed = 16'h0;
    tick(40);
    press_key(0);
    press_key(3);
    n_checks++; if (ev_count - base != 3) $display("FAIL clean_count: got %0d want 3", ev_count - base); else n_pass++;
    n_checks++; if (got.size() < base + 3 || got[base] !== 4'h6 || got[base+1] !== 4'h1 || got[base+2] !== 4'hA)
      $display("FAIL clean_seq: got %0d events, want 6,1,A", got.size() - base);
    else n_pass++;
    n_checks++; if (data !== 32'h0000061A) $display("FAIL clean_data: got %h want 0000061a", data); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] m_data = 32'h0;
    logic [3:0]  exp_q[$];
    int base;
    pulse_clr();
    base = ev_count;
    for (int i = 0; i < 8; i++) begin
      int idx = $urandom_range(0, 15);
      press_key(idx);
      exp_q.push_back(keymap[idx]);
      m_data = {m_data[27:0], keymap[idx]};
    end
    n_checks++; if (ev_count - base != 8) $display("FAIL rand_count: got %0d want 8", ev_count - base); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got.size() <= base + i) $display("FAIL rand_ev%0d: missing, want %h", i, exp_q[i]);
      else if (got[base+i] !== exp_q[i]) $display("FAIL rand_ev%0d: got %h want %h", i, got[base+i], exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (data !== m_data) $display("FAIL rand_data: got %h want %h", data, m_data); else n_pass++;
  endtask

  task automatic test_bounce();
    bit ok;
    int base = ev_count;
    logic [31:0] d0 = data;
    wait_row(4'b1011, ok);
    n_checks++; if (!ok) $display("FAIL bounce_wait: row=%b want 1011", row); else n_pass++;
    pressed[9] = 1'b1;
    tick(8);
    pressed = 16'h0;
    tick(4);
    n_checks++; if (row !== 4'b0111) $display("FAIL bounce_row: got %b want 0111", row); else n_pass++;
    tick(40);
    n_checks++; if (ev_count != base) $display("FAIL bounce_event: got %0d events want 0", ev_count - base); else n_pass++;
    n_checks++; if (data !== d0) $display("FAIL bounce_data: got %h want %h", data, d0); else n_pass++;
  endtask

  task automatic test_ghost();
    bit ok;
    int base = ev_count;
    logic [31:0] d0 = data;
    wait_row(4'b1110, ok);
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    tick(60);
    pressed = 16'h0;
    tick(40);
    n_checks++; if (ev_count != base) $display("FAIL ghost_event: got %0d events want 0", ev_count - base); else n_pass++;
    n_checks++; if (data !== d0) $display("FAIL ghost_data: got %h want %h", data, d0); else n_pass++;
  endtask

  task automatic test_overrun();
    kif.i_key_ready = 1'b0;
    pulse_clr();
    press_key(5);
    press_key(10);
    n_checks++; if (kif.o_key !== 4'h5 || kif.o_key_valid !== 1'b1)
      $display("FAIL ovr_hold: key=%h valid=%b want 5/1", kif.o_key, kif.o_key_valid); else n_pass++;
    n_checks++; if (ovr !== 1'b1) $display("FAIL ovr_flag: got %b want 1", ovr); else n_pass++;
    n_checks++; if (data !== 32'h59) $display("FAIL ovr_data: got %h want 00000059", data); else n_pass++;
    pulse_clr();
    n_checks++; if (data !== 32'h0 || ovr !== 1'b0)
      $display("FAIL clr_effect: data=%h ovr=%b want 0/0", data, ovr); else n_pass++;
    n_checks++; if (kif.o_key_valid !== 1'b1) $display("FAIL clr_valid: got %b want 1", kif.o_key_valid); else n_pass++;
    kif.i_key_ready = 1'b1;
    tick(1);
    n_checks++; if (kif.o_key_valid !== 1'b0) $display("FAIL ovr_drain: valid=%b want 0", kif.o_key_valid); else n_pass++;
  endtask

  task automatic test_random_overrun();
    int n = $urandom_range(2, 5);
    logic [3:0]  first = 4'h0;
    logic [31:0] m_data = 32'h0;
    kif.i_key_ready = 1'b0;
    pulse_clr();
    for (int i = 0; i < n; i++) begin
      int idx = $urandom_range(0, 15);
      press_key(idx);
      if (i == 0) first = keymap[idx];
      m_data = {m_data[27:0], keymap[idx]};
    end
    n_checks++; if (kif.o_key !== first || kif.o_key_valid !== 1'b1 || ovr !== 1'b1)
      $display("FAIL rovr_state: key=%h valid=%b ovr=%b want %h/1/1", kif.o_key, kif.o_key_valid, ovr, first); else n_pass++;
    n_checks++; if (data !== m_data) $display("FAIL rovr_data: got %h want %h", data, m_data); else n_pass++;
    kif.i_key_ready = 1'b1;
    tick(2);
  endtask

  task automatic test_back_to_back();
    bit ok;
    kif.i_key_ready = 1'b0;
    pulse_clr();
    press_key(2);
    wait_row(row_of(7), ok);
    pressed[7] = 1'b1;
    tick(11);
    kif.i_key_ready = 1'b1;
    tick(1);
    n_checks++; if (kif.o_key !== 4'hB || kif.o_key_valid !== 1'b1)
      $display("FAIL b2b_load: key=%h valid=%b want b/1", kif.o_key, kif.o_key_valid); else n_pass++;
    n_checks++; if (ovr !== 1'b0) $display("FAIL b2b_ovr: got %b want 0", ovr); else n_pass++;
    tick(1);
    n_checks++; if (kif.o_key_valid !== 1'b0) $display("FAIL b2b_clear: valid=%b want 0", kif.o_key_valid); else n_pass++;
    pressed = 16'h0;
    tick(40);
  endtask

  task automatic test_clr_with_emit();
    bit ok;
    wait_row(row_of(14), ok);
    pressed[14] = 1'b1;
    tick(11);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    n_checks++; if (data !== 32'h0000000F) $display("FAIL clr_emit_data: got %h want 0000000f", data); else n_pass++;
    n_checks++; if (kif.o_key_valid !== 1'b1 || ovr !== 1'b0)
      $display("FAIL clr_emit_hs: valid=%b ovr=%b want 1/0", kif.o_key_valid, ovr); else n_pass++;
    tick(2);
    pressed = 16'h0;
    tick(40);
  endtask

  task automatic test_reset_mid_press();
    bit ok;
    int idx = $urandom_range(0, 3);
    int base;
    wait_row(4'b1110, ok);
    pressed[idx] = 1'b1;
    tick(6);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    base = ev_count;
    tick(11);
    n_checks++; if (kif.o_key_valid !== 1'b0 || ev_count != base)
      $display("FAIL rmp_early: valid=%b events=%0d want 0/0", kif.o_key_valid, ev_count - base); else n_pass++;
    tick(1);
    n_checks++; if (kif.o_key_valid !== 1'b1 || kif.o_key !== keymap[idx])
      $display("FAIL rmp_event: valid=%b key=%h want 1/%h", kif.o_key_valid, kif.o_key, keymap[idx]); else n_pass++;
    n_checks++; if (data !== {28'h0, keymap[idx]}) $display("FAIL rmp_data: got %h want %h", data, {28'h0, keymap[idx]}); else n_pass++;
    tick(2);
    pressed = 16'h0;
    tick(40);
  endtask

  task automatic test_autorepeat();
    bit ok;
    int held = 17;
    int exp_ev;
    int base;
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_ev = 1 + held / RC;
`else
    exp_ev = 1;
`endif
    pulse_clr();
    base = ev_count;
    wait_row(row_of(13), ok);
    pressed[13] = 1'b1;
    tick(81);
    pressed = 16'h0;
    tick(40);
    n_checks++; if (ev_count - base != exp_ev) $display("FAIL repeat_count: got %0d want %0d", ev_count - base, exp_ev); else n_pass++;
    n_checks++; if (data !== 32'h0 || kif.o_key !== 4'h0)
      $display("FAIL repeat_data: data=%h key=%h want 0/0", data, kif.o_key); else n_pass++;
  endtask

  initial begin
    kif.i_key_ready = 1'b1;
    test_reset();
    test_clean_presses();
    test_random();
    test_bounce();
    test_ghost();
    test_overrun();
    test_random_overrun();
    test_back_to_back();
    test_clr_with_emit();
    test_reset_mid_press();
    test_autorepeat();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
